// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the data-memory access unit: funct3 size codes,
// FSM states and the lane helpers used when an access is accepted.
package mem_access_unit_pkg;

  localparam logic [2:0] FUNCT_B  = 3'b000;
  localparam logic [2:0] FUNCT_H  = 3'b001;
  localparam logic [2:0] FUNCT_W  = 3'b010;
  localparam logic [2:0] FUNCT_BU = 3'b100;
  localparam logic [2:0] FUNCT_HU = 3'b101;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;
  typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W} size_t;

  // Undefined funct codes behave as full-word accesses.
  function automatic size_t access_size(input logic [2:0] funct);
    case (funct)
      FUNCT_B, FUNCT_BU: return SIZE_B;
      FUNCT_H, FUNCT_HU: return SIZE_H;
      default:           return SIZE_W;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input size_t size, input logic [1:0] lane);
    case (size)
      SIZE_B:  return 4'b0001 << lane;
      SIZE_H:  return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input size_t size, input logic [31:0] data);
    case (size)
      SIZE_B:  return {4{data[7:0]}};
      SIZE_H:  return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Load lane select and sign/zero extension of the returned memory word.
module load_formatter
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr, 3'b000} +: 8];
  assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    case (funct)
      FUNCT_B:  result = {{24{byte_sel[7]}}, byte_sel};
      FUNCT_BU: result = {24'h0, byte_sel};
      FUNCT_H:  result = {{16{half_sel[15]}}, half_sel};
      FUNCT_HU: result = {16'h0, half_sel};
      default:  result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access FSM (IDLE -> ACCESS -> DONE) with pipeline stall.
// Optional misalignment trap: define MISALIGN_TRAP_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_cntl_MemWrite,
  input  logic        MEM_cntl_MemRead,
  input  logic [2:0]  MEM_funct,
  input  logic [31:0] MEM_ALUResult,
  input  logic [31:0] MEM_WriteMemData,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] MEM_DMemReadData_width,
  output logic        mem_stall,
  output logic        mem_misaligned
);

  state_t      state_q, state_d;
  logic        access_req, misaligned, accept;
  size_t       size_in;
  logic [1:0]  lane_in;
  logic        we_q;
  logic [2:0]  funct_q;
  logic [1:0]  lane_q;
  logic [31:0] addr_q, wdata_q, result_q, load_value;
  logic [3:0]  be_q;

  assign access_req = MEM_cntl_MemRead | MEM_cntl_MemWrite;
  assign size_in    = access_size(MEM_funct);

  // Low address bits below the access size are dropped, so H uses addr[1] and W none.
  // NOTE: combinational blocks assign a default first so no path infers a latch.
  always_comb begin
    lane_in = 2'b00;
    case (size_in)
      SIZE_B:  lane_in = MEM_ALUResult[1:0];
      SIZE_H:  lane_in = {MEM_ALUResult[1], 1'b0};
      default: lane_in = 2'b00;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((size_in == SIZE_H) && MEM_ALUResult[0]) ||
                      ((size_in == SIZE_W) && (MEM_ALUResult[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign accept = (state_q == ST_IDLE) && access_req && !misaligned;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_ACCESS;
      ST_ACCESS: if (dmem_ready) state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign mem_stall      = accept || (state_q == ST_ACCESS);
  assign mem_misaligned = (state_q == ST_IDLE) && access_req && misaligned;
  assign dmem_req       = (state_q == ST_ACCESS);
  assign dmem_we        = dmem_req && we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign dmem_be        = be_q;
  assign MEM_DMemReadData_width = result_q;

  load_formatter u_load_formatter (
    .rdata  (dmem_rdata),
    .addr   (lane_q),
    .funct  (funct_q),
    .result (load_value)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: data registers are reset too, since the bus and load result must read zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      funct_q  <= 3'b000;
      lane_q   <= 2'b00;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      be_q     <= 4'h0;
      result_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // A simultaneous read and write request performs the write only.
        we_q    <= MEM_cntl_MemWrite;
        funct_q <= MEM_funct;
        lane_q  <= lane_in;
        addr_q  <= {MEM_ALUResult[31:2], 2'b00};
        wdata_q <= replicate(size_in, MEM_WriteMemData);
        be_q    <= byte_enables(size_in, lane_in);
      end
      if ((state_q == ST_ACCESS) && dmem_ready && !we_q) begin
        result_q <= load_value;
      end
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port MEM_cntl_MemWrite, input, 1 bit: store request from the EX/MEM stage register.
REQ-004 SHALL have port MEM_cntl_MemRead, input, 1 bit: load request.
REQ-005 SHALL have port MEM_funct, input, 3 bits: access size and sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-006 SHALL have port MEM_ALUResult, input, 32 bits: byte address.
REQ-007 SHALL have port MEM_WriteMemData, input, 32 bits: store data, right-aligned.
REQ-008 SHALL have port dmem_req, output, 1 bit: memory request valid.
REQ-009 SHALL have port dmem_we, output, 1 bit: 1 = write.
REQ-010 SHALL have port dmem_addr, output, 32 bits: word-aligned address, bits [1:0] = 00.
REQ-011 SHALL have port dmem_wdata, output, 32 bits: lane-replicated store data.
REQ-012 SHALL have port dmem_be, output, 4 bits: byte enables.
REQ-013 SHALL have port dmem_ready, input, 1 bit: memory accepts or completes the access.
REQ-014 SHALL have port dmem_rdata, input, 32 bits: read word, valid when dmem_ready=1.
REQ-015 SHALL have port MEM_DMemReadData_width, output, 32 bits: formatted load result.
REQ-016 SHALL have port mem_stall, output, 1 bit: holds IF through EX/MEM.
REQ-017 SHALL have port mem_misaligned, output, 1 bit: misalignment flag.

Function
REQ-018 SHALL implement an FSM with states IDLE, ACCESS and DONE.
REQ-019 In IDLE with MemRead or MemWrite = 1, SHALL assert mem_stall combinationally, register address, data, funct and op, and go to ACCESS.
REQ-020 In IDLE with no request, SHALL stay in IDLE with mem_stall = 0.
REQ-021 In ACCESS, SHALL hold dmem_req = 1 and all dmem_* outputs stable until dmem_ready = 1 is sampled; mem_stall SHALL stay 1.
REQ-022 On the edge where dmem_ready = 1 in ACCESS, SHALL register the formatted read result and go to DONE.
REQ-023 In DONE, SHALL drive mem_stall = 0 and dmem_req = 0, hold MEM_DMemReadData_width, and return to IDLE unconditionally without re-triggering on the same instruction.
REQ-024 Minimum latency SHALL be 2 stall cycles with zero-wait memory.
REQ-025 If MemWrite and MemRead are both 1, SHALL perform a write only.
REQ-026 Byte enables SHALL be: B = 0001 << addr[1:0]; H = addr[1] ? 1100 : 0011; W and all other funct values = 1111.
REQ-027 dmem_wdata SHALL be: B = byte replicated ×4; H = halfword replicated ×2; W = as is.
REQ-028 Loads SHALL select the lane by addr[1:0]; B/H SHALL sign-extend, BU/HU SHALL zero-extend, and undefined funct values SHALL be treated as W.
REQ-029 Stores SHALL leave MEM_DMemReadData_width unchanged.

Reset
REQ-030 On reset = 1 at a clock edge, SHALL enter IDLE from any state, including mid-ACCESS, and abandon the access.
REQ-031 After reset, SHALL drive dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, MEM_DMemReadData_width and mem_misaligned to 0.
REQ-032 mem_stall SHALL follow REQ-019/REQ-020 from the first cycle after reset.

Configuration
REQ-033 Macro MISALIGN_TRAP_EN SHALL control misalignment handling.
REQ-034 When MISALIGN_TRAP_EN is defined, an H access with addr[0] = 1 or a W access with addr[1:0] != 00 seen in IDLE SHALL set mem_misaligned = 1 combinationally for that cycle, issue no memory request, not stall, and stay in IDLE.
REQ-035 When MISALIGN_TRAP_EN is undefined, mem_misaligned SHALL be tied to 0, and the low address bits SHALL be ignored down to the access size (H uses addr[1], W uses none) before the normal access.

Structure
REQ-036 A shared package SHALL hold the funct3 size encodings and the FSM state enum.
REQ-037 Load lane select and extension SHALL be a combinational sub-module named load_formatter, taking rdata, addr[1:0] and funct and producing the 32-bit result.

Verification
REQ-038 LW at 0x0000_0010 with ready=1 on the first ACCESS cycle, rdata = 0xDEAD_BEEF -> dmem_addr = 0x10, be = 1111, mem_stall high for 2 cycles, result 0xDEAD_BEEF in DONE.
REQ-039 LB at 0x13, rdata = 0x8000_0000 -> result 0xFFFF_FF80; LBU at the same address -> 0x0000_0080.
REQ-040 SH at 0x102, data 0x1234_BEEF -> dmem_addr = 0x100, be = 1100, wdata = 0xBEEF_BEEF, we = 1.
REQ-041 LW with ready held low 3 cycles -> dmem_req and dmem_addr stable for 4 ACCESS cycles, mem_stall high for 5 cycles total.
REQ-042 Reset asserted during ACCESS -> next cycle state is IDLE, dmem_req = 0, all outputs 0.
REQ-043 LW at 0x101 -> with MISALIGN_TRAP_EN: mem_misaligned = 1 for one cycle, no dmem_req, no stall; without: access at 0x100, be = 1111.
